// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FWFT read-side consumer of the async FIFO.
package fifo_rd_pkg;

    localparam int unsigned OBUF_DEPTH = 3;
    localparam int unsigned OBUF_IDX_W = 2;
    localparam int unsigned OBUF_CNT_W = 2;

    typedef logic [OBUF_IDX_W-1:0] obuf_idx_t;
    typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;

    // Circular index advance over OBUF_DEPTH entries (2 -> 0).
    function automatic obuf_idx_t obuf_idx_inc(input obuf_idx_t idx);
        if (idx == obuf_idx_t'(OBUF_DEPTH - 1)) begin
            return '0;
        end
        return obuf_idx_t'(idx + obuf_idx_t'(1));
    endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// FIFO read port (empty/r_en/rdata) plus downstream valid/ready stream.
// master = the consumer block, slave = FIFO/downstream side.
interface fifo_rd_fwft_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import fifo_rd_pkg::*;

    logic                  empty;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    obuf_cnt_t             ob_level;

    modport master (
        input  empty, rdata, m_ready,
        output r_en, m_valid, m_data, ob_level
    );

    modport slave (
        output empty, rdata, m_ready,
        input  r_en, m_valid, m_data, ob_level
    );

endinterface

// File: rtl/fifo_rd_obuf.sv
// 3-entry circular register buffer with push/pop and occupancy count.
// Entry storage is deliberately not reset; only indices and count are.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_c_o,
    output obuf_cnt_t             count_o
);

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    obuf_idx_t             wr_idx_q, wr_idx_d;
    obuf_idx_t             rd_idx_q, rd_idx_d;
    obuf_cnt_t             count_q,  count_d;
    logic                  pop_ok_c;

    assign pop_ok_c = pop_i && (count_q != '0);

    // Index and occupancy next-state.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (push_i) begin
            wr_idx_d = obuf_idx_inc(wr_idx_q);
        end
        if (pop_ok_c) begin
            rd_idx_d = obuf_idx_inc(rd_idx_q);
        end
        case ({push_i, pop_ok_c})
            2'b10:   count_d = obuf_cnt_t'(count_q + obuf_cnt_t'(1));
            2'b01:   count_d = obuf_cnt_t'(count_q - obuf_cnt_t'(1));
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge rclk) begin
        if (push_i) begin
            mem_q[wr_idx_q] <= push_data_i;
        end
    end

    assign head_data_c_o = mem_q[rd_idx_q];
    assign count_o       = count_q;

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        !(push_i && (count_q == obuf_cnt_t'(OBUF_DEPTH)))
    );
`endif

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-domain FWFT adapter: issues r_en against the FIFO and stages read data
// in a 3-entry buffer. Optional delivered-word counter under FIFO_RD_WORD_CNT_EN.
module fifo_rd_fwft
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_RD_WORD_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    fifo_rd_fwft_if.master        bus
`ifdef FIFO_RD_WORD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_word_cnt
`endif
);

    logic                  inflight_q, inflight_d;
    logic                  r_en_c;
    logic                  pop_c;
    logic [2:0]            occupancy_c;
    obuf_cnt_t             count;
    logic [DATA_WIDTH-1:0] head_data_c;

    // Reserve a slot for every outstanding read so the buffer can never overflow;
    // m_ready is intentionally absent from this path.
    assign occupancy_c = 3'(count) + 3'(inflight_q);
    assign r_en_c      = !bus.empty && (occupancy_c < 3'(OBUF_DEPTH));
    assign inflight_d  = r_en_c;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign pop_c = bus.m_valid && bus.m_ready;

    fifo_rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .push_i        (inflight_q),
        .push_data_i   (bus.rdata),
        .pop_i         (pop_c),
        .head_data_c_o (head_data_c),
        .count_o       (count)
    );

    assign bus.r_en     = r_en_c;
    assign bus.m_valid  = (count != '0);
    assign bus.m_data   = head_data_c;
    assign bus.ob_level = count;

`ifdef FIFO_RD_WORD_CNT_EN
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (pop_c) begin
            word_cnt_d = CNT_WIDTH'(word_cnt_q + CNT_WIDTH'(1));
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign rd_word_cnt = word_cnt_q;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        occupancy_c <= 3'(OBUF_DEPTH)
    );

    a_head_stable: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data))
    );
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: FIFO source model driving empty/rdata, queue scoreboard
// on the output stream, and an occupancy model derived from accepted reads and pops.
module tb_fifo_rd_fwft;
    import fifo_rd_pkg::*;

    localparam int unsigned DW = 8;
`ifdef FIFO_RD_WORD_CNT_EN
    localparam int unsigned CW = 4;
    logic [CW-1:0] rd_word_cnt;
`endif

    logic rclk = 1'b0;
    logic rrst_n;

    fifo_rd_fwft_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_fwft #(
        .DATA_WIDTH (DW)
`ifdef FIFO_RD_WORD_CNT_EN
        ,
        .CNT_WIDTH  (CW)
`endif
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .bus         (bus)
`ifdef FIFO_RD_WORD_CNT_EN
        ,
        .rd_word_cnt (rd_word_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] pend;
    logic [DW-1:0] data_prev;
    bit            acc_d1, acc_d2;
    bit            stall_prev;
    bit            gate, ready_drv, rst_drv;
    int            arrived, popped;

    typedef struct {
        int load;
        bit rdy;
        bit r_en;
        bit vld;
        int lvl;
        int data;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int n, input int base, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] w;
            w = rnd ? DW'($urandom) : DW'(base + k);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // One rclk: drive at the falling edge, check 1 time unit later.
    task automatic tick();
        int exp_level;
        bit exp_r_en;
        bit acc;
        @(negedge rclk);
        rrst_n      = rst_drv;
        bus.m_ready = ready_drv;
        if (!rst_drv) begin
            src_q.delete();
            exp_q.delete();
            acc_d1     = 1'b0;
            acc_d2     = 1'b0;
            arrived    = 0;
            popped     = 0;
            stall_prev = 1'b0;
        end
        bus.rdata = acc_d1 ? pend : DW'($urandom);
        bus.empty = !rst_drv || gate || (src_q.size() == 0);
        #1;
        // Words in the buffer = reads whose data has landed minus words taken.
        arrived  += int'(acc_d2);
        exp_level = arrived - popped;
        exp_r_en  = !bus.empty && ((exp_level + int'(acc_d1)) < 3);
        chk("ob_level", int'(bus.ob_level), exp_level);
        chk("m_valid", int'(bus.m_valid), int'(exp_level != 0));
        chk("r_en", int'(bus.r_en), int'(exp_r_en));
        chk("r_en_vs_empty", int'(bus.r_en & bus.empty), 0);
        if (stall_prev && bus.m_valid) begin
            chk("m_data_hold", int'(bus.m_data), int'(data_prev));
        end
`ifdef FIFO_RD_WORD_CNT_EN
        chk("rd_word_cnt", int'(rd_word_cnt), popped % (1 << CW));
`endif
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got 0x%0h expected no word at %0t", bus.m_data, $time);
            end else begin
                chk("m_data_order", int'(bus.m_data), int'(exp_q.pop_front()));
            end
            popped++;
        end
        stall_prev = bus.m_valid && !bus.m_ready;
        data_prev  = bus.m_data;
        acc = bus.r_en && !bus.empty && (src_q.size() != 0);
        if (acc) begin
            pend = src_q.pop_front();
        end
        acc_d2 = acc_d1;
        acc_d1 = acc;
    endtask

    // mode 0: ready=1; mode 1: ready toggles; mode 2: random ready, empty gated every other cycle.
    task automatic run(input string name, input int budget, input int mode);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid === 1'b1) && n < budget) begin
            case (mode)
                0:       begin ready_drv = 1'b1;   gate = 1'b0; end
                1:       begin ready_drv = !n[0];  gate = 1'b0; end
                default: begin ready_drv = ($urandom_range(0, 1) == 1); gate = n[0]; end
            endcase
            tick();
            n++;
        end
        chk({name, "_undelivered"}, exp_q.size(), 0);
        gate = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_drv = 1'b0;
        repeat (cycles) tick();
        rst_drv = 1'b1;
    endtask

    initial begin
        bit found;
        rst_drv     = 1'b0;
        gate        = 1'b0;
        ready_drv   = 1'b0;
        rrst_n      = 1'b0;
        bus.empty   = 1'b1;
        bus.rdata   = '0;
        bus.m_ready = 1'b0;
        pend        = '0;
        data_prev   = '0;
        acc_d1      = 1'b0;
        acc_d2      = 1'b0;
        stall_prev  = 1'b0;
        arrived     = 0;
        popped      = 0;

        vec[0] = '{5, 1'b1, 1'b1, 1'b0, 0, 0};
        vec[1] = '{0, 1'b1, 1'b1, 1'b0, 0, 0};
        vec[2] = '{0, 1'b1, 1'b1, 1'b1, 1, 'h11};
        vec[3] = '{0, 1'b1, 1'b1, 1'b1, 1, 'h12};
        vec[4] = '{0, 1'b1, 1'b1, 1'b1, 1, 'h13};
        vec[5] = '{0, 1'b1, 1'b0, 1'b1, 1, 'h14};
        vec[6] = '{0, 1'b1, 1'b0, 1'b1, 1, 'h15};
        vec[7] = '{0, 1'b1, 1'b0, 1'b0, 0, 0};
        vec[8] = '{0, 1'b1, 1'b0, 1'b0, 0, 0};

        do_reset(3);

        // Idle after reset with nothing in the FIFO.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_r_en", int'(bus.r_en), 0);
            chk("idle_m_valid", int'(bus.m_valid), 0);
            chk("idle_ob_level", int'(bus.ob_level), 0);
        end

        // Fall-through latency and back-to-back delivery of 0x11..0x15.
        for (int i = 0; i < 9; i++) begin
            if (vec[i].load != 0) load(vec[i].load, 'h11, 1'b0);
            ready_drv = vec[i].rdy;
            tick();
            chk($sformatf("tbl%0d_r_en", i), int'(bus.r_en), int'(vec[i].r_en));
            chk($sformatf("tbl%0d_m_valid", i), int'(bus.m_valid), int'(vec[i].vld));
            chk($sformatf("tbl%0d_ob_level", i), int'(bus.ob_level), vec[i].lvl);
            if (vec[i].vld) chk($sformatf("tbl%0d_m_data", i), int'(bus.m_data), vec[i].data);
        end
        chk("tbl_all_delivered", exp_q.size(), 0);

        // Back-pressure: buffer fills to 3 and the FIFO keeps the rest.
        load(8, 'h11, 1'b0);
        ready_drv = 1'b0;
        repeat (12) tick();
        chk("bp_ob_level", int'(bus.ob_level), 3);
        chk("bp_r_en", int'(bus.r_en), 0);
        chk("bp_empty", int'(bus.empty), 0);
        chk("bp_m_data", int'(bus.m_data), 'h11);
        run("bp_release", 40, 0);

        // Alternating m_ready with random data.
        load(16, 0, 1'b1);
        run("toggle", 100, 1);

        // Async reset with two words buffered and one read in flight.
        load(6, 'h31, 1'b0);
        ready_drv = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (int'(bus.ob_level) == 2 && acc_d2) found = 1'b1;
        end
        chk("rst_setup_reached", int'(found), 1);
        rst_drv = 1'b0;
        tick();
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_ob_level", int'(bus.ob_level), 0);
        chk("rst_r_en", int'(bus.r_en), 0);
        tick();
        rst_drv = 1'b1;
        tick();
        load(4, 'hA1, 1'b0);
        run("post_rst", 30, 0);

        // Empty toggling every cycle with random back-pressure.
        load(12, 0, 1'b1);
        run("empty_toggle", 200, 2);

        // Random soak.
        for (int r = 0; r < 20; r++) begin
            load(int'($urandom_range(0, 6)), 0, 1'b1);
            for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
                ready_drv = ($urandom_range(0, 3) != 0);
                gate      = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        gate = 1'b0;
        run("soak", 300, 0);

`ifdef FIFO_RD_WORD_CNT_EN
        do_reset(2);
        load(10, 'h50, 1'b0);
        run("cnt10", 40, 0);
        chk("cnt_after_10", int'(rd_word_cnt), 10);
        load(7, 'h60, 1'b0);
        run("cnt17", 40, 0);
        tick();
        chk("cnt_after_17_wrap", int'(rd_word_cnt), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
- Read-domain consumer of the async FIFO read interface. Drives r_en into the read-pointer handler and captures FIFO memory read data.
- Presents that data as a first-word-fall-through valid/ready stream to downstream logic in the rclk domain.
- A 3-entry output buffer sustains 1 word/cycle with no combinational path from m_ready to r_en.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- CNT_WIDTH, 16, width of rd_word_cnt (optional feature only).

Ports:
- rclk  input  1  read-domain clock.
- rrst_n  input  1  reset, asynchronous, active-low.
- empty  input  1  registered FIFO empty flag from the read-pointer handler.
- r_en  output  1  read request to the pointer handler and memory; a read is accepted when r_en & !empty.
- rdata  input  DATA_WIDTH  memory read data; valid exactly 1 rclk after an accepted read.
- m_valid  output  1  head of output buffer is valid.
- m_data  output  DATA_WIDTH  head word.
- m_ready  input  1  downstream accept; a pop occurs when m_valid & m_ready.
- ob_level  output  2  output-buffer occupancy, 0..3.
- rd_word_cnt  output  CNT_WIDTH  words delivered; present only with FIFO_RD_WORD_CNT_EN.

Behaviour:
- Internal state:
  - 3-entry circular buffer with wr_idx/rd_idx (0..2, wrap 2->0).
  - count register (0..3).
  - inflight register (1 bit): a read was accepted last cycle.
- r_en = !empty && (count + inflight) < 3. Combinational from registers and empty only; it never depends on m_ready. r_en is never asserted while empty=1.
- inflight <= r_en (accepted read) each cycle.
- When inflight=1: rdata is written to entry wr_idx and wr_idx advances.
- m_valid = (count != 0). m_data = buf[rd_idx]. On pop, rd_idx advances.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Ordering: words leave in exactly the order they were read. No drops, no duplicates.
- m_data must remain stable while m_valid=1 and m_ready=0.
- Latency: empty falling to 0 with buffer idle -> r_en the same cycle -> m_valid 2 rclk after that edge.
- Throughput: with continuous data and m_ready=1, one word per cycle after a 2-cycle fill; steady state has count at 1..2.
- Overflow safety: count + inflight <= 3 at all times, so a push into a full buffer is impossible. Simulation assertion required.
- Underflow: no pop when count=0, because m_valid=0.
- m_ready=0 for a long time: the buffer fills to 3, r_en drops, and the FIFO retains the remaining words.
- empty toggling every cycle: r_en follows empty combinationally; no spurious push.
- Reset (async, any time, including mid-transfer):
  - count=0, inflight=0, wr_idx=rd_idx=0, ob_level=0, m_valid=0, rd_word_cnt=0.
  - r_en=0 while rrst_n=0, because the handler holds empty=1.
  - Buffer data contents are not reset. An in-flight read is discarded; the pointer handler is reset by the same rrst_n.
- ob_level = count.

Optional Feature:
- Macro FIFO_RD_WORD_CNT_EN.
- Defined: rd_word_cnt port exists. It increments by 1 on every pop and wraps modulo 2^CNT_WIDTH. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rd_pkg holds:
  - localparam OBUF_DEPTH=3.
  - typedef obuf_idx_t (logic [1:0]).
  - typedef obuf_cnt_t (logic [1:0]).
- One natural sub-module: fifo_rd_obuf (3-entry register buffer with push/pop/count). The parent holds the r_en/inflight issue logic and the optional counter.

Test Plan:
- Reset then idle, empty=1 -> r_en=0, m_valid=0, ob_level=0 for 20 cycles.
- Load 5 words 0x11..0x15, m_ready=1 -> r_en on the cycle empty drops; m_valid 2 cycles later; then 0x11..0x15 on 5 consecutive cycles.
- 8 words, m_ready=0 -> ob_level reaches 3, r_en=0 while empty=0, m_data=0x11 stable; release m_ready -> all 8 delivered in order.
- m_ready toggling 1010..., 16 words -> data in order, no loss; assertion count+inflight<=3 holds throughout.
- rrst_n asserted with ob_level=2 and inflight=1 -> m_valid=0, ob_level=0 immediately; after release, reads restart cleanly with the new data.
- With FIFO_RD_WORD_CNT_EN, deliver 10 words -> rd_word_cnt=10. With CNT_WIDTH=4 and 17 words -> rd_word_cnt=1.
